// File: rtl/noc_flit_injector.sv
// noc_flit_injector
// Source-side network interface feeding router injection port 0. Whole-packet
// requests from the host are cut into head/body/tail flits. A flit is only
// issued on a VC while that VC still holds a credit for a downstream buffer
// slot. Credits come back through the router's credit-return word.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   pkt_valid/ready packet request handshake; ready only while idle
//   pkt_dst/vc/len  packet destination, VC and flit count (0 means 1)
//   flit_out        registered flit {full, vc, head, tail, pad=0, dst}
//   cr_in           credit return {valid, vc}
//   credit_cnt      per-VC credit counters packed together, VC0 at the LSBs
//   busy            a packet is in progress
//   cr_err          sticky flag: a credit was returned to a full counter
//
// Optional build macro INJ_STATS_EN adds stat_flits, stat_pkts and stat_stall
// (32-bit free-running counters of flits, tails and stall cycles).
module noc_flit_injector #(
    parameter int NUM_VC    = 4,
    parameter int VC_W      = 2,
    parameter int DST_W     = 14,
    parameter int LEN_W     = 4,
    parameter int BUF_DEPTH = 4,
    parameter int CRED_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pkt_valid,
    output logic                        pkt_ready,
    input  logic [DST_W-1:0]            pkt_dst,
    input  logic [VC_W-1:0]             pkt_vc,
    input  logic [LEN_W-1:0]            pkt_len,
    output logic [2+VC_W+2+DST_W-1:0]   flit_out,
    input  logic [VC_W:0]               cr_in,
    output logic [NUM_VC*CRED_W-1:0]    credit_cnt,
    output logic                        busy,
    output logic                        cr_err
`ifdef INJ_STATS_EN
    ,
    output logic [31:0]                 stat_flits,
    output logic [31:0]                 stat_pkts,
    output logic [31:0]                 stat_stall
`endif
);

    typedef enum logic [1:0] {IDLE, SEND, STALL} state_t;

    state_t               state;
    state_t               state_next;
    logic [DST_W-1:0]     dst_q;
    logic [VC_W-1:0]      vc_q;
    logic [LEN_W-1:0]     rem_q;
    logic                 first_q;
    logic [CRED_W-1:0]    credit [NUM_VC];

    logic                 cr_valid;
    logic [VC_W-1:0]      cr_vc;
    logic                 send;
    logic                 last;
    logic                 cr_hits_vc;

    assign cr_valid   = cr_in[VC_W];
    assign cr_vc      = cr_in[VC_W-1:0];
    // The send decision looks at the count before this cycle's update. A credit
    // arriving in the same cycle therefore cannot rescue a zero-credit VC.
    assign send       = (state == SEND) && (credit[vc_q] != '0);
    assign last       = (rem_q == LEN_W'(1));
    assign cr_hits_vc = cr_valid && (cr_vc == vc_q);

    assign pkt_ready  = (state == IDLE);
    assign busy       = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. STALL also watches the credit arriving this cycle, so
    // the flit leaves as early as the credit allows.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pkt_valid) state_next = SEND;
            SEND:    if (!send) state_next = STALL;
                     else if (last) state_next = IDLE;
            STALL:   if ((credit[vc_q] != '0) || cr_hits_vc) state_next = SEND;
            default: state_next = IDLE;
        endcase
    end

    // Packet context and registered flit output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_q    <= '0;
            vc_q     <= '0;
            rem_q    <= '0;
            first_q  <= 1'b0;
            flit_out <= '0;
        end else begin
            if (state == IDLE && pkt_valid) begin
                dst_q   <= pkt_dst;
                vc_q    <= pkt_vc;
                rem_q   <= (pkt_len == '0) ? LEN_W'(1) : pkt_len;
                first_q <= 1'b1;
            end else if (send) begin
                rem_q   <= rem_q - LEN_W'(1);
                first_q <= 1'b0;
            end
            flit_out <= send ? {1'b1, vc_q, first_q, last, 1'b0, dst_q} : '0;
        end
    end

    // Per-VC credit counters. A send and a return on the same VC cancel out.
    // A lone return to a full counter saturates it and raises cr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                credit[v] <= CRED_W'(BUF_DEPTH);
            end
            cr_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (cr_valid && cr_vc == VC_W'(v) && !(send && vc_q == VC_W'(v))) begin
                    if (credit[v] == CRED_W'(BUF_DEPTH)) begin
                        cr_err <= 1'b1;
                    end else begin
                        credit[v] <= credit[v] + CRED_W'(1);
                    end
                end else if (send && vc_q == VC_W'(v) && !(cr_valid && cr_vc == VC_W'(v))) begin
                    credit[v] <= credit[v] - CRED_W'(1);
                end
            end
        end
    end

    // Pack the counters into the flat output port
    always_comb begin
        credit_cnt = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            credit_cnt[v*CRED_W +: CRED_W] = credit[v];
        end
    end

`ifdef INJ_STATS_EN
    // Statistics counters; they wrap naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_flits <= '0;
            stat_pkts  <= '0;
            stat_stall <= '0;
        end else begin
            if (send) stat_flits <= stat_flits + 32'd1;
            if (send && last) stat_pkts <= stat_pkts + 32'd1;
            if (state == STALL) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_flit_injector.sv
// tb_noc_flit_injector
// Directed testbench for noc_flit_injector. Every expected value is computed by
// hand from the packet timing: the packet is accepted on one edge, and each
// SEND cycle with credit makes a flit visible after the next edge.
// Define INJ_STATS_EN to also check the statistics counters.
module tb_noc_flit_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [13:0] pkt_dst;
    logic [1:0]  pkt_vc;
    logic [3:0]  pkt_len;
    logic [19:0] flit_out;
    logic [2:0]  cr_in;
    logic [11:0] credit_cnt;
    logic        busy;
    logic        cr_err;
`ifdef INJ_STATS_EN
    logic [31:0] stat_flits;
    logic [31:0] stat_pkts;
    logic [31:0] stat_stall;
`endif

    int checks   = 0;
    int failures = 0;

    noc_flit_injector dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_dst    (pkt_dst),
        .pkt_vc     (pkt_vc),
        .pkt_len    (pkt_len),
        .flit_out   (flit_out),
        .cr_in      (cr_in),
        .credit_cnt (credit_cnt),
        .busy       (busy),
        .cr_err     (cr_err)
`ifdef INJ_STATS_EN
        ,
        .stat_flits (stat_flits),
        .stat_pkts  (stat_pkts),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge and then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count one comparison and report it if the values differ
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [13:0] dst,
                                 input logic [1:0] vc, input logic [3:0] len,
                                 input logic [2:0] cr);
        pkt_valid = valid;
        pkt_dst   = dst;
        pkt_vc    = vc;
        pkt_len   = len;
        cr_in     = cr;
    endtask

    function automatic logic [19:0] mkFlit(input logic [1:0] vc, input logic head,
                                           input logic tail, input logic [13:0] dst);
        return {1'b1, vc, head, tail, 1'b0, dst};
    endfunction

    function automatic logic [2:0] credOf(input int v);
        return credit_cnt[v*3 +: 3];
    endfunction

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 14'd0, 2'd0, 4'd0, 3'b000);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset_ready", 64'(pkt_ready), 64'd1);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_flit", 64'(flit_out), 64'd0);
        checkOutput("reset_crerr", 64'(cr_err), 64'd0);
        checkOutput("reset_credits", 64'(credit_cnt), 64'h924);

        // Three-flit packet on vc1
        applyStimulus(1'b1, 14'd12, 2'd1, 4'd3, 3'b000);
        tick();
        pkt_valid = 1'b0;
        checkOutput("p1_accept_flit", 64'(flit_out), 64'd0);
        checkOutput("p1_busy", 64'(busy), 64'd1);
        checkOutput("p1_ready_low", 64'(pkt_ready), 64'd0);
        tick();
        checkOutput("p1_head", 64'(flit_out), 64'(mkFlit(2'd1, 1'b1, 1'b0, 14'd12)));
        tick();
        checkOutput("p1_body", 64'(flit_out), 64'(mkFlit(2'd1, 1'b0, 1'b0, 14'd12)));
        tick();
        checkOutput("p1_tail", 64'(flit_out), 64'(mkFlit(2'd1, 1'b0, 1'b1, 14'd12)));
        checkOutput("p1_ready_back", 64'(pkt_ready), 64'd1);
        checkOutput("p1_credit1", 64'(credOf(1)), 64'd1);
        tick();
        checkOutput("p1_idle_flit", 64'(flit_out), 64'd0);

        // Credit return to a full counter
        cr_in = 3'b100;
        tick();
        cr_in = 3'b000;
        checkOutput("ovf_credit0", 64'(credOf(0)), 64'd4);
        checkOutput("ovf_crerr", 64'(cr_err), 64'd1);

        // Six-flit packet on vc0 runs out of credit after four flits
        applyStimulus(1'b1, 14'd100, 2'd0, 4'd6, 3'b000);
        tick();
        pkt_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("p2_flit%0d", i), 64'(flit_out),
                        64'(mkFlit(2'd0, (i == 0), 1'b0, 14'd100)));
        end
        checkOutput("p2_credit_empty", 64'(credOf(0)), 64'd0);
        tick();
        checkOutput("p2_stall_flit", 64'(flit_out), 64'd0);
        checkOutput("p2_stall_busy", 64'(busy), 64'd1);
        tick();
        tick();
        checkOutput("p2_stall_hold", 64'(flit_out), 64'd0);
        cr_in = 3'b100;
        tick();
        cr_in = 3'b000;
        checkOutput("p2_credit_back", 64'(credOf(0)), 64'd1);
        tick();
        checkOutput("p2_flit5", 64'(flit_out), 64'(mkFlit(2'd0, 1'b0, 1'b0, 14'd100)));
        tick();
        checkOutput("p2_stall2_flit", 64'(flit_out), 64'd0);
        tick();
        cr_in = 3'b100;
        tick();
        cr_in = 3'b000;
        tick();
        checkOutput("p2_tail", 64'(flit_out), 64'(mkFlit(2'd0, 1'b0, 1'b1, 14'd100)));
        checkOutput("p2_ready", 64'(pkt_ready), 64'd1);
        checkOutput("p2_crerr_sticky", 64'(cr_err), 64'd1);
`ifdef INJ_STATS_EN
        checkOutput("stat_stall", 64'(stat_stall), 64'd5);
        checkOutput("stat_flits", 64'(stat_flits), 64'd9);
        checkOutput("stat_pkts", 64'(stat_pkts), 64'd2);
`endif

        // vc2 stalls at zero credit and a returning credit releases the tail
        applyStimulus(1'b1, 14'd7, 2'd2, 4'd5, 3'b000);
        tick();
        pkt_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("p3_credit_empty", 64'(credOf(2)), 64'd0);
        tick();
        checkOutput("p3_stall_flit", 64'(flit_out), 64'd0);
        cr_in = 3'b110;
        tick();
        cr_in = 3'b000;
        checkOutput("p3_credit_back", 64'(credOf(2)), 64'd1);
        tick();
        checkOutput("p3_tail", 64'(flit_out), 64'(mkFlit(2'd2, 1'b0, 1'b1, 14'd7)));
        checkOutput("p3_credit_after", 64'(credOf(2)), 64'd0);

        // Send and return on vc3 in the same cycle leave the count unchanged
        applyStimulus(1'b1, 14'd5, 2'd3, 4'd2, 3'b000);
        tick();
        pkt_valid = 1'b0;
        tick();
        tick();
        checkOutput("p4_credit3", 64'(credOf(3)), 64'd2);
        applyStimulus(1'b1, 14'd9, 2'd3, 4'd2, 3'b000);
        tick();
        pkt_valid = 1'b0;
        cr_in = 3'b111;
        tick();
        cr_in = 3'b000;
        checkOutput("p5_head", 64'(flit_out), 64'(mkFlit(2'd3, 1'b1, 1'b0, 14'd9)));
        checkOutput("p5_credit_same", 64'(credOf(3)), 64'd2);
        tick();
        checkOutput("p5_credit_dec", 64'(credOf(3)), 64'd1);

        // len=0 becomes a single head+tail flit
        applyStimulus(1'b1, 14'd3, 2'd1, 4'd0, 3'b000);
        tick();
        pkt_valid = 1'b0;
        tick();
        checkOutput("p6_single", 64'(flit_out), 64'(mkFlit(2'd1, 1'b1, 1'b1, 14'd3)));
        checkOutput("p6_ready", 64'(pkt_ready), 64'd1);
        tick();
        checkOutput("p6_after", 64'(flit_out), 64'd0);

        // Top up vc1 and then reset in the middle of a packet
        cr_in = 3'b101;
        for (int i = 0; i < 3; i++) tick();
        cr_in = 3'b000;
        checkOutput("p7_credit1", 64'(credOf(1)), 64'd3);
        applyStimulus(1'b1, 14'd33, 2'd1, 4'd5, 3'b000);
        tick();
        pkt_valid = 1'b0;
        tick();
        tick();
        checkOutput("p7_body", 64'(flit_out), 64'(mkFlit(2'd1, 1'b0, 1'b0, 14'd33)));
        rst = 1'b1;
        #1;
        checkOutput("rst2_flit", 64'(flit_out), 64'd0);
        checkOutput("rst2_busy", 64'(busy), 64'd0);
        checkOutput("rst2_ready", 64'(pkt_ready), 64'd1);
        checkOutput("rst2_crerr", 64'(cr_err), 64'd0);
        checkOutput("rst2_credits", 64'(credit_cnt), 64'h924);
`ifdef INJ_STATS_EN
        checkOutput("rst2_stat_flits", 64'(stat_flits), 64'd0);
`endif
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 14'd44, 2'd1, 4'd2, 3'b000);
        tick();
        pkt_valid = 1'b0;
        tick();
        checkOutput("p8_head", 64'(flit_out), 64'(mkFlit(2'd1, 1'b1, 1'b0, 14'd44)));
        tick();
        checkOutput("p8_tail", 64'(flit_out), 64'(mkFlit(2'd1, 1'b0, 1'b1, 14'd44)));
        checkOutput("p8_credit1", 64'(credOf(1)), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
